// File: rtl/cmp_ext_pipe_if.sv
// Valid/ready bus for cmp_ext_pipe: operand/op/tag request side and result/flags response side.
interface cmp_ext_pipe_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_uns;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_lt;
  logic             out_eq;
  logic             out_gt;
  logic             out_ovf;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_a, in_b, in_uns, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_lt, out_eq, out_gt, out_ovf, out_tag
  );

  modport master (
    output in_valid, in_a, in_b, in_uns, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_lt, out_eq, out_gt, out_ovf, out_tag
  );
endinterface

// File: rtl/cmp_ext_pipe.sv
// Two-stage signed/unsigned compare, min/max/sub unit with valid/ready flow control.
// Optional equal-result handshake counter enabled by defining CMP_EQCNT_EN.
module cmp_ext_pipe #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  cmp_ext_pipe_if.slave bus
`ifdef CMP_EQCNT_EN
  ,
  output logic [15:0]   eq_cnt,
  input  logic          eq_cnt_clr
`endif
);

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_MIN  = 2'b01,
    OP_MAX  = 2'b10,
    OP_SUB  = 2'b11
  } op_e;

  logic             v1, v2;
  logic [WIDTH:0]   a1, b1;
  logic             uns1;
  op_e              op1;
  logic [TAG_W-1:0] tag1;

  logic [WIDTH-1:0] res2;
  logic             lt2, eq2, gt2, ovf2;
  logic [TAG_W-1:0] tag2;

  logic             adv2, acc;
  logic [WIDTH:0]   a_x, b_x;
  logic [WIDTH+1:0] d;
  logic             lt_c, eq_c, gt_c, ovf_c;
  logic [WIDTH-1:0] res_c;

  assign adv2         = ~v2 | bus.out_ready;
  assign bus.in_ready = ~v1 | adv2;
  assign acc          = bus.in_valid & bus.in_ready;

  // Mode-dependent extension gives one extra bit so both modes compare as signed.
  assign a_x = {~bus.in_uns & bus.in_a[WIDTH-1], bus.in_a};
  assign b_x = {~bus.in_uns & bus.in_b[WIDTH-1], bus.in_b};

  always_comb begin
    d     = {a1[WIDTH], a1} - {b1[WIDTH], b1};
    lt_c  = d[WIDTH+1];
    eq_c  = (a1 == b1);
    gt_c  = ~lt_c & ~eq_c;
    res_c = a1[WIDTH-1:0];
    case (op1)
      OP_MIN:  res_c = lt_c ? a1[WIDTH-1:0] : b1[WIDTH-1:0];
      OP_MAX:  res_c = gt_c ? a1[WIDTH-1:0] : b1[WIDTH-1:0];
      OP_SUB:  res_c = d[WIDTH-1:0];
      default: res_c = a1[WIDTH-1:0];
    endcase
    // d always fits WIDTH+1 bits, so signed overflow reduces to the top two bits disagreeing.
    ovf_c = (op1 == OP_SUB) & (uns1 ? lt_c : (d[WIDTH] ^ d[WIDTH-1]));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1   <= 1'b0;
      a1   <= '0;
      b1   <= '0;
      uns1 <= 1'b0;
      op1  <= OP_PASS;
      tag1 <= '0;
    end else if (acc) begin
      v1   <= 1'b1;
      a1   <= a_x;
      b1   <= b_x;
      uns1 <= bus.in_uns;
      op1  <= op_e'(bus.in_op);
      tag1 <= bus.in_tag;
    end else if (v1 & adv2) begin
      v1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2   <= 1'b0;
      res2 <= '0;
      lt2  <= 1'b0;
      eq2  <= 1'b0;
      gt2  <= 1'b0;
      ovf2 <= 1'b0;
      tag2 <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        res2 <= res_c;
        lt2  <= lt_c;
        eq2  <= eq_c;
        gt2  <= gt_c;
        ovf2 <= ovf_c;
        tag2 <= tag1;
      end
    end
  end

  assign bus.out_valid = v2;
  assign bus.out_res   = res2;
  assign bus.out_lt    = lt2;
  assign bus.out_eq    = eq2;
  assign bus.out_gt    = gt2;
  assign bus.out_ovf   = ovf2;
  assign bus.out_tag   = tag2;

`ifdef CMP_EQCNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eq_cnt <= '0;
    end else if (eq_cnt_clr) begin
      eq_cnt <= '0;
    end else if (v2 & bus.out_ready & eq2 & (eq_cnt != '1)) begin
      eq_cnt <= eq_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/cmp_ext_pipe.md
Name: cmp_ext_pipe

Overview:
- Parametrised, pipelined successor to the CPU's combinational compare sign-extender.
- Accepts two WIDTH-bit operands in signed or unsigned mode. Each operand is extended to WIDTH+1 bits, then compared and combined.
- Outputs lt/eq/gt flags and an op-selected result (pass, min, max, subtract) through a 2-stage valid/ready pipeline.
- Sits between the register-file read stage and branch/ALU writeback logic.

Parameters:
- WIDTH, 64, operand and result width in bits (must be >= 2).
- TAG_W, 5, width of the sideband tag carried alongside each transaction (e.g. destination register index).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  pipeline can accept the input this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_uns  input  1  1 = unsigned (zero-extend), 0 = signed (sign-extend).
- in_op  input  2  00 PASS_A, 01 MIN, 10 MAX, 11 SUB.
- in_tag  input  TAG_W  sideband tag, returned unchanged.
- out_valid  output  1  output transaction present.
- out_ready  input  1  downstream accepts the output.
- out_res  output  WIDTH  op result.
- out_lt  output  1  A < B under the selected mode.
- out_eq  output  1  A == B.
- out_gt  output  1  A > B under the selected mode.
- out_ovf  output  1  SUB overflow under the selected mode; 0 for other ops.
- out_tag  output  TAG_W  tag of this transaction.

Behaviour:
- Reset: asynchronous, active-low on reset_n. Reset is asserted when reset_n=0; it is applied immediately, without waiting for clk. All valid bits clear, so out_valid=0 and in_ready=1 (stage 1 is empty). out_res, out_lt, out_eq, out_gt, out_ovf and out_tag are all 0.
- Extension:
  - a_x = {~in_uns & in_a[WIDTH-1], in_a}; b_x is formed from in_b the same way. Both are WIDTH+1 bits.
  - All comparison uses two's-complement signed interpretation of a_x and b_x.
- Stage 1:
  - On in_valid & in_ready, register a_x, b_x, in_uns, in_op and in_tag, and set v1=1.
  - If a stage-1 entry moves to stage 2 and no new input is accepted in the same cycle, v1 clears.
- Stage 2:
  - When stage 2 advances and v1=1, compute d = a_x - b_x in WIDTH+2 bits.
  - Register the flags: lt = d sign bit; eq = (a_x == b_x); gt = ~lt & ~eq.
  - Register the result:
    - PASS_A: in_a.
    - MIN: lt ? a : b.
    - MAX: gt ? a : b.
    - SUB: low WIDTH bits of d.
  - ovf = (op==SUB) & (d[WIDTH:0] does not fit the mode). Signed: d[WIDTH] != d[WIDTH-1]. Unsigned: borrow, i.e. lt.
  - Set v2=1.
- Handshake:
  - adv2 = ~v2 | out_ready.
  - in_ready = ~v1 | adv2.
  - Stage 1 moves to stage 2 whenever v1 & adv2.
  - When adv2 and v1=0, v2 clears.
  - out_valid = v2. The output holds stable while out_valid & ~out_ready.
  - No combinational path from in_* to out_*. The only combinational path from out_ready is to in_ready.
- Latency and throughput: 2 cycles from acceptance to out_valid with no stall. Throughput is 1 transaction per cycle when out_ready=1.
- Boundary conditions:
  - Full pipeline: v1 and v2 set with out_ready=0 drives in_ready=0, and no data is lost.
  - Simultaneous accept and drain in the same cycle is legal and keeps full throughput.
  - Data inputs are ignored when in_valid=0.
  - Asserting reset mid-operation discards all in-flight transactions.

Optional Feature:
- Macro: CMP_EQCNT_EN.
- Defined:
  - Adds output port eq_cnt (16 bits) and input port eq_cnt_clr (1 bit).
  - eq_cnt increments by 1 on each output handshake (out_valid & out_ready) where out_eq=1. It saturates at 16'hFFFF.
  - eq_cnt_clr=1 synchronously zeroes the counter and takes priority over an increment in the same cycle.
  - Reset clears eq_cnt to 0.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
- WIDTH=8 signed: A=8'hFF, B=8'h01, op=MIN, uns=0 -> 2 cycles later out_lt=1, out_res=8'hFF. Repeat with uns=1 -> out_gt=1, out_res=8'h01.
- WIDTH=8 SUB signed: A=8'h80, B=8'h01 -> out_res=8'h7F, out_ovf=1. Unsigned, same operands -> out_ovf=0, out_gt=1.
- Back-to-back stream of 10 transactions, tags 0..9, out_ready=1 -> outputs on consecutive cycles, tags in order.
- out_ready=0 for 5 cycles while feeding -> in_ready falls after 2 accepts. Outputs stay stable. After release, tags come out in order with no loss or duplicate.
- Assert reset_n=0 mid-stream between clock edges -> out_valid=0 and all outputs 0 immediately. Post-reset accept yields correct result.
- CMP_EQCNT_EN defined: 3 equal and 2 unequal pairs -> eq_cnt=3. Pulse eq_cnt_clr together with an equal handshake -> eq_cnt=0. Preload toward saturation -> eq_cnt holds at 16'hFFFF.
